// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds dispatched instructions until
// both operands are valid, snoops the ALU/LSB broadcast buses and issues one per cycle.
module alu_rs #(
   parameter int unsigned RS_SIZE   = 8,
   parameter int unsigned ROB_POS_W = 4,
   parameter int unsigned DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 issue_valid,
   input  logic [6:0]           issue_opcode,
   input  logic [2:0]           issue_funct3,
   input  logic                 issue_funct7,
   input  logic                 issue_rs1_rdy,
   input  logic [DATA_W-1:0]    issue_val1,
   input  logic [ROB_POS_W-1:0] issue_rs1_tag,
   input  logic                 issue_rs2_rdy,
   input  logic [DATA_W-1:0]    issue_val2,
   input  logic [ROB_POS_W-1:0] issue_rs2_tag,
   input  logic [DATA_W-1:0]    issue_imm,
   input  logic [DATA_W-1:0]    issue_pc,
   input  logic [ROB_POS_W-1:0] issue_rob_pos,
   output logic                 rs_full,
   input  logic                 alu_cdb_valid,
   input  logic [ROB_POS_W-1:0] alu_cdb_rob_pos,
   input  logic [DATA_W-1:0]    alu_cdb_val,
   input  logic                 lsb_cdb_valid,
   input  logic [ROB_POS_W-1:0] lsb_cdb_rob_pos,
   input  logic [DATA_W-1:0]    lsb_cdb_val,
   output logic                 alu_en,
   output logic [6:0]           alu_opcode,
   output logic [2:0]           alu_funct3,
   output logic                 alu_funct7,
   output logic [DATA_W-1:0]    alu_val1,
   output logic [DATA_W-1:0]    alu_val2,
   output logic [DATA_W-1:0]    alu_imm,
   output logic [DATA_W-1:0]    alu_pc,
   output logic [ROB_POS_W-1:0] alu_rob_pos
);

   localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   typedef struct packed {
      logic                 busy;
      logic [6:0]           opcode;
      logic [2:0]           funct3;
      logic                 funct7;
      logic                 rdy1;
      logic                 rdy2;
      logic [ROB_POS_W-1:0] tag1;
      logic [ROB_POS_W-1:0] tag2;
      logic [DATA_W-1:0]    val1;
      logic [DATA_W-1:0]    val2;
      logic [DATA_W-1:0]    imm;
      logic [DATA_W-1:0]    pc;
      logic [ROB_POS_W-1:0] rob_pos;
   } entry_t;

   entry_t ent_q [RS_SIZE];
   entry_t ent_d [RS_SIZE];
   entry_t disp_ent;

   logic [RS_SIZE-1:0] busy_vec;
   logic               sel_any;
   logic [IDX_W-1:0]   sel_idx;
   logic               free_any;
   logic [IDX_W-1:0]   free_idx;
   logic               en_d;

   // Operand capture from the broadcast buses; the ALU bus wins a double match.
   function automatic logic [DATA_W:0] snoop(input logic rdy_in,
                                             input logic [DATA_W-1:0] val_in,
                                             input logic [ROB_POS_W-1:0] tag);
      logic [DATA_W:0] res;
      res = {rdy_in, val_in};
      if (!rdy_in) begin
         if (alu_cdb_valid && (alu_cdb_rob_pos == tag))
            res = {1'b1, alu_cdb_val};
         else if (lsb_cdb_valid && (lsb_cdb_rob_pos == tag))
            res = {1'b1, lsb_cdb_val};
      end
      return res;
   endfunction

   // Lowest-index ready entry and lowest-index free entry, from registered state.
   always_comb begin : pick
      sel_any  = 1'b0;
      sel_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      busy_vec = '0;
      for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
         busy_vec[i] = ent_q[i].busy;
         if (ent_q[i].busy && ent_q[i].rdy1 && ent_q[i].rdy2) begin
            sel_any = 1'b1;
            sel_idx = IDX_W'(i);
         end
         if (!ent_q[i].busy) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   assign rs_full = &busy_vec;

   // Dispatch payload with same-cycle broadcast bypass.
   always_comb begin : dispatch
      disp_ent         = '0;
      disp_ent.busy    = 1'b1;
      disp_ent.opcode  = issue_opcode;
      disp_ent.funct3  = issue_funct3;
      disp_ent.funct7  = issue_funct7;
      disp_ent.tag1    = issue_rs1_tag;
      disp_ent.tag2    = issue_rs2_tag;
      disp_ent.imm     = issue_imm;
      disp_ent.pc      = issue_pc;
      disp_ent.rob_pos = issue_rob_pos;
      {disp_ent.rdy1, disp_ent.val1} = snoop(issue_rs1_rdy, issue_val1, issue_rs1_tag);
      {disp_ent.rdy2, disp_ent.val2} = snoop(issue_rs2_rdy, issue_val2, issue_rs2_tag);
   end

   // Next entry state: wakeup, issue release, dispatch write, rollback flush.
   always_comb begin : next_state
      en_d = sel_any && !rollback;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
         ent_d[i] = ent_q[i];
         {ent_d[i].rdy1, ent_d[i].val1} = snoop(ent_q[i].rdy1, ent_q[i].val1, ent_q[i].tag1);
         {ent_d[i].rdy2, ent_d[i].val2} = snoop(ent_q[i].rdy2, ent_q[i].val2, ent_q[i].tag2);
      end
      if (sel_any)
         ent_d[sel_idx].busy = 1'b0;
      if (issue_valid && free_any)
         ent_d[free_idx] = disp_ent;
      if (rollback) begin
         for (int i = 0; i < int'(RS_SIZE); i++)
            ent_d[i].busy = 1'b0;
      end
   end

   // State and issue registers; everything freezes while rdy is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(RS_SIZE); i++)
            ent_q[i] <= '0;
         alu_en      <= 1'b0;
         alu_opcode  <= '0;
         alu_funct3  <= '0;
         alu_funct7  <= 1'b0;
         alu_val1    <= '0;
         alu_val2    <= '0;
         alu_imm     <= '0;
         alu_pc      <= '0;
         alu_rob_pos <= '0;
      end else if (rdy) begin
         for (int i = 0; i < int'(RS_SIZE); i++)
            ent_q[i] <= ent_d[i];
         alu_en <= en_d;
         if (en_d) begin
            alu_opcode  <= ent_q[sel_idx].opcode;
            alu_funct3  <= ent_q[sel_idx].funct3;
            alu_funct7  <= ent_q[sel_idx].funct7;
            alu_val1    <= ent_q[sel_idx].val1;
            alu_val2    <= ent_q[sel_idx].val2;
            alu_imm     <= ent_q[sel_idx].imm;
            alu_pc      <= ent_q[sel_idx].pc;
            alu_rob_pos <= ent_q[sel_idx].rob_pos;
         end
      end
   end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
Reservation station and issue scheduler for the integer ALU. It accepts decoded ALU/branch/JALR/LUI/AUIPC instructions from dispatch and holds each one until both source operands are valid. Operands are captured from the two result broadcast buses (ALU and load/store unit). Each cycle it selects at most one ready entry and drives the ALU issue interface for one cycle. It sits between the dispatch stage and the ALU, and it is flushed by ROB rollback.

Parameters:
RS_SIZE, 8, number of entries (power of two, 2..16)
ROB_POS_W, 4, ROB index width
DATA_W, 32, operand/data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global ready; low = freeze all state
rollback  in  1  ROB misprediction flush
issue_valid  in  1  dispatch presents an instruction
issue_opcode  in  7  opcode
issue_funct3  in  3  funct3
issue_funct7  in  1  funct7 bit 5
issue_rs1_rdy  in  1  val1 valid at dispatch
issue_val1  in  DATA_W  rs1 value
issue_rs1_tag  in  ROB_POS_W  ROB producer of rs1 when not ready
issue_rs2_rdy  in  1  val2 valid at dispatch
issue_val2  in  DATA_W  rs2 value
issue_rs2_tag  in  ROB_POS_W  ROB producer of rs2 when not ready
issue_imm  in  DATA_W  immediate
issue_pc  in  DATA_W  instruction PC
issue_rob_pos  in  ROB_POS_W  destination ROB slot
rs_full  out  1  no free entry (combinational)
alu_cdb_valid  in  1  ALU broadcast valid
alu_cdb_rob_pos  in  ROB_POS_W  ALU broadcast tag
alu_cdb_val  in  DATA_W  ALU broadcast value
lsb_cdb_valid  in  1  LSB broadcast valid
lsb_cdb_rob_pos  in  ROB_POS_W  LSB broadcast tag
lsb_cdb_val  in  DATA_W  LSB broadcast value
alu_en  out  1  issue pulse to ALU
alu_opcode, alu_funct3, alu_funct7  out  7/3/1  issued fields
alu_val1, alu_val2, alu_imm, alu_pc  out  DATA_W  issued operands
alu_rob_pos  out  ROB_POS_W  issued ROB slot

Behaviour:
- Reset (async, rst=1): all entries not busy; alu_en=0; all alu_* outputs 0; rs_full=0.
- Per entry: busy, opcode/funct3/funct7, val1/val2, rdy1/rdy2, tag1/tag2, imm, pc, rob_pos.
- rs_full = all entries busy. issue_valid while rs_full is ignored (no write, no error).
- Dispatch: on a clk edge with rdy=1, rollback=0, issue_valid=1 and not full, write the lowest-index free entry.
- Same-cycle bypass at dispatch: if rsN is not ready and its tag matches a valid broadcast in that cycle, store the broadcast value with rdyN=1. The ALU bus takes priority if both buses match (not expected in legal traffic).
- Wakeup: every busy entry with rdyN=0 compares tagN against both buses each cycle. On a match it latches the value and sets rdyN=1.
- Ready = busy & rdy1 & rdy2, evaluated on registered state. An entry written or woken at edge T is eligible at edge T+1 at the earliest.
- Select: the lowest-index ready entry. At the edge, alu_en<=1, the alu_* outputs are loaded from that entry, and busy is cleared. If nothing is ready, alu_en<=0 and the alu_* outputs hold their values.
- Throughput: at most one dispatch and one issue per cycle, and they may occur in the same cycle. A slot freed by issue at edge T is writable from edge T+1 (rs_full uses pre-edge state).
- Latency: an operand-ready dispatch at edge T issues (alu_en=1) after edge T+1.
- Opcodes without rs2 (ARITHI, JALR, LUI, AUIPC) and without rs1 (LUI, AUIPC) are dispatched with the unused rdy flag set to 1. The block does not decode opcodes.
- Rollback (priority over dispatch and issue; effective only when rdy=1): all busy cleared and alu_en<=0 at that edge. Broadcasts in the same cycle are discarded.
- rdy=0: no state or output register changes; broadcasts in that cycle are lost by design, because the upstream units also freeze.
- rst asserted mid-operation clears state immediately, without waiting for clk.

Test Plan:
- Dispatch ADDI (rs1_rdy=1, val1=5, imm=7, rob_pos=3) into an empty RS -> alu_en=1 exactly one cycle, two edges later; alu_val1=5, alu_imm=7, alu_rob_pos=3; rs_full=0 throughout.
- Dispatch ADD with rs2 waiting on tag 6, then lsb_cdb_valid with rob_pos=6 and val=0x10 three cycles later -> issue one edge after the broadcast, with alu_val2=0x10.
- Dispatch with rs1 tag 2 in the same cycle as alu_cdb tag 2, val=9 -> entry captured ready; issues next edge with alu_val1=9.
- Fill 8 entries, all waiting on tag 1 -> rs_full=1, and a 9th issue_valid is dropped. Broadcast tag 1 -> 8 consecutive alu_en pulses in index order 0..7, and rs_full drops after the first.
- Fill 4 entries, then pulse rollback together with a ready entry and a dispatch -> no alu_en; RS empty; a subsequent dispatch lands in entry 0.
- Hold rdy=0 for 3 cycles with a ready entry -> no alu_en and state unchanged; alu_en fires at the first edge with rdy=1. Assert rst between edges -> alu_en drops immediately.
